// File: rtl/hint_scheduler_pkg.sv
// Shared types and constants for the hint scheduler and its letter picker.
package hint_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIRST,
    REVEAL,
    WAIT_NEXT,
    DONE
  } hint_state_t;

  localparam logic [7:0] LFSR_SEED   = 8'hB5;
  localparam int         NUM_LETTERS = 5;

endpackage

// File: rtl/hint_scheduler_letter_picker.sv
// Picks the first unrevealed letter at or after a pseudo-random start, wrapping mod 5.
module letter_picker
  import hint_pkg::*;
(
  input  logic [2:0]             start,
  input  logic [NUM_LETTERS-1:0] mask,
  output logic [2:0]             pos
);

  logic [2:0] base;
  logic [3:0] sum;
  logic [2:0] idx;
  logic       found;

  // A full mask has no free letter; pos then stays 0 and is never used.
  always_comb begin
    base  = (start >= 3'd5) ? start - 3'd5 : start;
    pos   = 3'd0;
    found = 1'b0;
    sum   = 4'd0;
    idx   = 3'd0;
    for (int k = 0; k < NUM_LETTERS; k++) begin
      sum = {1'b0, base} + 4'(k);
      idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
      if (!found && !mask[idx]) begin
        pos   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hint_scheduler.sv
// Sequences letter reveals for one drawing round: first delay, then fixed intervals.
module hint_scheduler
  import hint_pkg::*;
#(
  parameter longint unsigned FIRST_DELAY_CYC = 64'd6_000_000_000,
  parameter longint unsigned INTERVAL_CYC    = 64'd2_500_000_000,
  parameter int              CNT_W           = 33,
  parameter int              MAX_HINTS       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   game_start,
  input  logic                   new_game,
  input  logic                   word_correct,
  input  logic                   timer_done,
  output logic [2:0]             hint_level,
  output logic                   hint_start,
  output logic [NUM_LETTERS-1:0] reveal_mask,
  output logic                   hint_pulse,
  output logic                   busy
);

  localparam logic [CNT_W-1:0] FIRST_LAST    = CNT_W'(FIRST_DELAY_CYC - 64'd1);
  localparam logic [CNT_W-1:0] INTERVAL_LAST = CNT_W'(INTERVAL_CYC - 64'd1);
  localparam logic [2:0]       HINT_LAST     = 3'(MAX_HINTS - 1);

  hint_state_t      state;
  logic [CNT_W-1:0] counter;
  logic [7:0]       lfsr;
  logic             game_start_q;
  logic [2:0]       pick_pos;
  logic             stop;

  letter_picker picker (
    .start (lfsr[2:0]),
    .mask  (reveal_mask),
    .pos   (pick_pos)
  );

  // Dropping game_start mid-round ends the round just like a guess or timeout.
  assign stop = word_correct | timer_done | ~game_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      lfsr         <= LFSR_SEED;
      game_start_q <= 1'b0;
      hint_level   <= 3'd0;
      hint_start   <= 1'b0;
      reveal_mask  <= '0;
      hint_pulse   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      lfsr         <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      game_start_q <= game_start;
      hint_pulse   <= 1'b0;
      if (new_game) begin
        state       <= IDLE;
        counter     <= '0;
        hint_level  <= 3'd0;
        hint_start  <= 1'b0;
        reveal_mask <= '0;
        busy        <= 1'b0;
      end else if ((state inside {WAIT_FIRST, REVEAL, WAIT_NEXT}) && stop) begin
        state      <= DONE;
        counter    <= '0;
        hint_start <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (game_start && !game_start_q) begin
              state   <= WAIT_FIRST;
              counter <= '0;
              busy    <= 1'b1;
            end
          end
          WAIT_FIRST: begin
            if (counter == FIRST_LAST) begin
              state   <= REVEAL;
              counter <= '0;
            end else begin
              counter <= counter + 1'b1;
            end
          end
          REVEAL: begin
            reveal_mask <= reveal_mask | (NUM_LETTERS'(1) << pick_pos);
            hint_level  <= hint_level + 3'd1;
            hint_pulse  <= 1'b1;
            hint_start  <= 1'b1;
            if (hint_level == HINT_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_NEXT;
            end
          end
          WAIT_NEXT: begin
            if (counter == INTERVAL_LAST) begin
              state   <= REVEAL;
              counter <= '0;
            end else begin
              counter <= counter + 1'b1;
            end
          end
          DONE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hint_scheduler.sv
// Directed bench for hint_scheduler (short delays) plus the standalone letter_picker.
module tb_hint_scheduler;
  import hint_pkg::*;

  logic       clk = 1'b0;
  logic       reset, game_start, new_game, word_correct, timer_done;
  logic [2:0] hint_level;
  logic       hint_start;
  logic [4:0] reveal_mask;
  logic       hint_pulse, busy;
  logic [2:0] pk_start, pk_pos;
  logic [4:0] pk_mask;
  logic [7:0] lfsr_m, lfsr_prev;
  int         compared = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  hint_scheduler #(
    .FIRST_DELAY_CYC (64'd10),
    .INTERVAL_CYC    (64'd4),
    .CNT_W           (33),
    .MAX_HINTS       (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .game_start   (game_start),
    .new_game     (new_game),
    .word_correct (word_correct),
    .timer_done   (timer_done),
    .hint_level   (hint_level),
    .hint_start   (hint_start),
    .reveal_mask  (reveal_mask),
    .hint_pulse   (hint_pulse),
    .busy         (busy)
  );

  letter_picker picker (
    .start (pk_start),
    .mask  (pk_mask),
    .pos   (pk_pos)
  );

  // Reference LFSR; lfsr_prev is the value the DUT used at the latest edge.
  always @(posedge clk) begin
    lfsr_prev <= lfsr_m;
    lfsr_m    <= reset ? 8'hB5 : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  function automatic logic [2:0] ref_pick(input logic [2:0] s, input logic [4:0] m);
    int         b;
    logic [2:0] idx;
    b = (s >= 3'd5) ? int'(s) - 5 : int'(s);
    for (int k = 0; k < 5; k++) begin
      idx = 3'((b + k) % 5);
      if (!m[idx]) return idx;
    end
    return 3'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    compared++; if (hint_level !== 3'd0) begin mismatched++; $display("FAIL reset_level: got %0d expected 0", hint_level); end
    compared++; if (hint_start !== 1'b0) begin mismatched++; $display("FAIL reset_start: got %b expected 0", hint_start); end
    compared++; if (reveal_mask !== 5'd0) begin mismatched++; $display("FAIL reset_mask: got %b expected 00000", reveal_mask); end
    compared++; if (hint_pulse !== 1'b0) begin mismatched++; $display("FAIL reset_pulse: got %b expected 0", hint_pulse); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_nominal();
    logic [4:0] exp_mask;
    logic [2:0] exp_pos;
    int         n;
    exp_mask = 5'd0;
    n = 0;
    game_start = 1'b1;
    step();
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL nom_busy_e0: got %b expected 1", busy); end
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c == 11 || c == 16 || c == 21 || c == 26) begin
        n++;
        exp_pos  = ref_pick(lfsr_prev[2:0], exp_mask);
        exp_mask = exp_mask | (5'd1 << exp_pos);
        compared++; if (hint_pulse !== 1'b1) begin mismatched++; $display("FAIL nom_pulse c=%0d: got %b expected 1", c, hint_pulse); end
        compared++; if (reveal_mask !== exp_mask) begin mismatched++; $display("FAIL nom_mask c=%0d: got %b expected %b", c, reveal_mask, exp_mask); end
        compared++; if (hint_level !== 3'(n)) begin mismatched++; $display("FAIL nom_level c=%0d: got %0d expected %0d", c, hint_level, n); end
        compared++; if (hint_start !== 1'b1) begin mismatched++; $display("FAIL nom_start c=%0d: got %b expected 1", c, hint_start); end
        compared++; if ($countones(reveal_mask) != n) begin mismatched++; $display("FAIL nom_popcount c=%0d: got %0d expected %0d", c, $countones(reveal_mask), n); end
      end else begin
        compared++; if (hint_pulse !== 1'b0) begin mismatched++; $display("FAIL nom_nopulse c=%0d: got %b expected 0", c, hint_pulse); end
      end
      if (c == 10) begin
        compared++; if (hint_start !== 1'b0) begin mismatched++; $display("FAIL nom_start_early: got %b expected 0", hint_start); end
      end
    end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL nom_done_busy: got %b expected 0", busy); end
    compared++; if (hint_start !== 1'b1) begin mismatched++; $display("FAIL nom_done_start: got %b expected 1", hint_start); end
    compared++; if (hint_level !== 3'd4) begin mismatched++; $display("FAIL nom_done_level: got %0d expected 4", hint_level); end
    compared++; if (reveal_mask !== exp_mask) begin mismatched++; $display("FAIL nom_done_mask: got %b expected %b", reveal_mask, exp_mask); end
    game_start = 1'b0;
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    compared++; if ({hint_level, hint_start, reveal_mask, hint_pulse, busy} !== 11'd0) begin mismatched++; $display("FAIL nom_clear: got %b expected all zero", {hint_level, hint_start, reveal_mask, hint_pulse, busy}); end
  endtask

  task automatic test_early_guess();
    logic [4:0] saved;
    saved = 5'd0;
    game_start = 1'b1;
    step();
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 11) begin
        saved = reveal_mask;
        compared++; if (hint_pulse !== 1'b1) begin mismatched++; $display("FAIL guess_pulse1: got %b expected 1", hint_pulse); end
      end else begin
        compared++; if (hint_pulse !== 1'b0) begin mismatched++; $display("FAIL guess_nopulse c=%0d: got %b expected 0", c, hint_pulse); end
      end
      if (c == 13) begin
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL guess_busy: got %b expected 0", busy); end
        compared++; if (hint_start !== 1'b0) begin mismatched++; $display("FAIL guess_start: got %b expected 0", hint_start); end
      end
      if (c == 12) word_correct = 1'b1;
      if (c == 13) word_correct = 1'b0;
    end
    compared++; if (hint_level !== 3'd1) begin mismatched++; $display("FAIL guess_level: got %0d expected 1", hint_level); end
    compared++; if (reveal_mask !== saved || $countones(reveal_mask) != 1) begin mismatched++; $display("FAIL guess_mask: got %b expected %b (one bit)", reveal_mask, saved); end
    compared++; if (hint_start !== 1'b0) begin mismatched++; $display("FAIL guess_start_end: got %b expected 0", hint_start); end
    game_start = 1'b0;
    new_game = 1'b1;
    step();
    new_game = 1'b0;
  endtask

  task automatic test_collision();
    game_start = 1'b1;
    step();
    for (int c = 1; c <= 22; c++) begin
      step();
      if (c == 11) begin
        compared++; if (hint_pulse !== 1'b1) begin mismatched++; $display("FAIL coll_pulse1: got %b expected 1", hint_pulse); end
      end else begin
        compared++; if (hint_pulse !== 1'b0) begin mismatched++; $display("FAIL coll_nopulse c=%0d: got %b expected 0", c, hint_pulse); end
      end
      if (c == 16) begin
        compared++; if (hint_level !== 3'd1) begin mismatched++; $display("FAIL coll_level: got %0d expected 1", hint_level); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL coll_busy: got %b expected 0", busy); end
        compared++; if (hint_start !== 1'b0) begin mismatched++; $display("FAIL coll_start: got %b expected 0", hint_start); end
        compared++; if ($countones(reveal_mask) != 1) begin mismatched++; $display("FAIL coll_popcount: got %0d expected 1", $countones(reveal_mask)); end
      end
      if (c == 15) timer_done = 1'b1;
      if (c == 16) timer_done = 1'b0;
    end
    game_start = 1'b0;
    new_game = 1'b1;
    step();
    new_game = 1'b0;
  endtask

  task automatic test_new_game_mid();
    logic [4:0] exp_mask;
    logic [2:0] exp_pos;
    game_start = 1'b1;
    step();
    for (int c = 1; c <= 13; c++) begin
      step();
      if (c == 11) begin
        compared++; if (hint_pulse !== 1'b1) begin mismatched++; $display("FAIL ng_pulse1: got %b expected 1", hint_pulse); end
      end
    end
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    compared++; if ({hint_level, hint_start, reveal_mask, hint_pulse, busy} !== 11'd0) begin mismatched++; $display("FAIL ng_clear: got %b expected all zero", {hint_level, hint_start, reveal_mask, hint_pulse, busy}); end
    step();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL ng_no_restart: got %b expected 0", busy); end
    game_start = 1'b0;
    step();
    game_start = 1'b1;
    step();
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL ng_restart_busy: got %b expected 1", busy); end
    exp_mask = 5'd0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 11) begin
        exp_pos  = ref_pick(lfsr_prev[2:0], exp_mask);
        exp_mask = exp_mask | (5'd1 << exp_pos);
        compared++; if (hint_pulse !== 1'b1) begin mismatched++; $display("FAIL ng_restart_pulse: got %b expected 1", hint_pulse); end
        compared++; if (reveal_mask !== exp_mask) begin mismatched++; $display("FAIL ng_restart_mask: got %b expected %b", reveal_mask, exp_mask); end
      end else begin
        compared++; if (hint_pulse !== 1'b0) begin mismatched++; $display("FAIL ng_restart_nopulse c=%0d: got %b expected 0", c, hint_pulse); end
      end
    end
    game_start = 1'b0;
    new_game = 1'b1;
    step();
    new_game = 1'b0;
  endtask

  task automatic test_start_fall();
    game_start = 1'b1;
    step();
    step();
    step();
    game_start = 1'b0;
    step();
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL fall_busy: got %b expected 0", busy); end
    for (int c = 0; c < 12; c++) step();
    compared++; if (hint_level !== 3'd0 || reveal_mask !== 5'd0) begin mismatched++; $display("FAIL fall_noreveal: got level %0d mask %b expected 0 00000", hint_level, reveal_mask); end
    new_game = 1'b1;
    step();
    new_game = 1'b0;
  endtask

  task automatic test_picker();
    logic [2:0] exp;
    pk_start = 3'd6; pk_mask = 5'b00010; #1;
    compared++; if (pk_pos !== 3'd2) begin mismatched++; $display("FAIL pick_s6: got %0d expected 2", pk_pos); end
    pk_start = 3'd4; pk_mask = 5'b10000; #1;
    compared++; if (pk_pos !== 3'd0) begin mismatched++; $display("FAIL pick_s4: got %0d expected 0", pk_pos); end
    for (int s = 0; s < 8; s++) begin
      for (int m = 0; m < 31; m++) begin
        pk_start = 3'(s);
        pk_mask  = 5'(m);
        #1;
        exp = ref_pick(3'(s), 5'(m));
        compared++; if (pk_pos !== exp) begin mismatched++; $display("FAIL pick s=%0d m=%b: got %0d expected %0d", s, 5'(m), pk_pos, exp); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    game_start = 1'b0;
    new_game = 1'b0;
    word_correct = 1'b0;
    timer_done = 1'b0;
    pk_start = 3'd0;
    pk_mask = 5'd0;
    step();
    step();
    reset = 1'b0;
    test_reset();
    test_nominal();
    test_early_guess();
    test_collision();
    test_new_game_mid();
    test_start_fall();
    test_picker();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
